// File: rtl/unpack_pkg.sv
// Shared definitions for the cache-line unpacker.
// - state_e         : unpacker control states
// - words_per_line  : number of DATA_WIDTH words in one CACHE_WIDTH line
// - idx_width       : bit width of the in-line word index (at least 1)
package unpack_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned words_per_line(input int unsigned cache_width,
                                                   input int unsigned data_width);
        return cache_width / data_width;
    endfunction

    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/line_fifo2.sv
// Two-entry line FIFO holding whole cache lines for the unpacker.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : write data_i into the tail (caller guarantees count_o < 2)
//   data_i    : line to write
//   pop_i     : drop the head entry (caller guarantees count_o > 0)
//   flush_i   : empty the FIFO; takes priority over push/pop
//   count_o   : number of stored lines (0..2)
//   head_o    : oldest stored line, driven straight from the storage registers
module line_fifo2 #(
    parameter int unsigned Width = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [1:0]       count_o,
    output logic [Width-1:0] head_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/line_unpack_pl.sv
// Pipelined cache-line unpacker feeding the number accumulator.
// Accepts CACHE_WIDTH-bit lines and emits one DATA_WIDTH-bit word per cycle, lowest word
// first, until size_in words of the job have been sent; surplus words are dropped.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle job start (IDLE only), size_in sampled with it
//   size_in     : job length in words
//   line_valid  : line_data valid; line_ready : line accepted this cycle when both high
//   inc, array  : registered word strobe and word data
//   word_last   : qualifies inc, final word of the job
//   size_out    : job length latched at start
//   done        : one-cycle pulse the cycle after the final word
//   busy        : job in progress
module line_unpack_pl
    import unpack_pkg::*;
#(
    parameter int unsigned CACHE_WIDTH = 512,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  size_in,
    input  logic                   line_valid,
    input  logic [CACHE_WIDTH-1:0] line_data,
    output logic                   line_ready,
    output logic                   inc,
    output logic [DATA_WIDTH-1:0]  array,
    output logic [DATA_WIDTH-1:0]  size_out,
    output logic                   word_last,
    output logic                   done,
    output logic                   busy
);

    localparam int unsigned W    = words_per_line(CACHE_WIDTH, DATA_WIDTH);
    localparam int unsigned IdxW = idx_width(W);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(W - 1);

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]  size_q, size_d;
    logic                   inc_q, inc_d;
    logic [DATA_WIDTH-1:0]  array_q, array_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic [1:0]             fifo_count;
    logic [CACHE_WIDTH-1:0] fifo_head;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_flush;
    logic [DATA_WIDTH-1:0]  head_word;

    // Ready uses the registered count only, so a same-cycle pop never opens it.
    assign line_ready = (state_q == StRun) && (fifo_count < 2'd2);
    assign fifo_push  = line_valid && line_ready;
    assign head_word  = fifo_head[32'(idx_q) * DATA_WIDTH +: DATA_WIDTH];

    line_fifo2 #(
        .Width (CACHE_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (line_data),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        size_d      = size_q;
        inc_d       = 1'b0;
        array_d     = array_q;
        last_d      = 1'b0;
        // done and busy trail the state by one cycle so busy covers the final word
        // and drops together with the done pulse.
        done_d      = (state_q == StDone);
        busy_d      = (state_q == StRun);
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (size_in != '0) begin
                        size_d      = size_in;
                        remaining_d = size_in;
                        state_d     = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end

            StRun: begin
                if (fifo_count != 2'd0) begin
                    inc_d       = 1'b1;
                    array_d     = head_word;
                    remaining_d = remaining_q - DATA_WIDTH'(1);
                    if (remaining_q == DATA_WIDTH'(1)) begin
                        // Final word: discard the head even if it still holds words.
                        last_d   = 1'b1;
                        fifo_pop = 1'b1;
                        idx_d    = '0;
                        state_d  = StDone;
                    end else if (idx_q == LastIdx) begin
                        fifo_pop = 1'b1;
                        idx_d    = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end

            StDone: begin
                fifo_flush = 1'b1;
                idx_d      = '0;
                state_d    = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            remaining_q <= '0;
            size_q      <= '0;
            inc_q       <= 1'b0;
            array_q     <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            size_q      <= size_d;
            inc_q       <= inc_d;
            array_q     <= array_d;
            last_q      <= last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign inc       = inc_q;
    assign array     = array_q;
    assign word_last = last_q;
    assign size_out  = size_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_line_unpack_pl.sv
// Scoreboard bench for line_unpack_pl: stimulus pushes expected words, a negedge
// monitor pops and compares every emitted word and checks done/busy framing.
module tb_line_unpack_pl;

    localparam int unsigned CW = 512;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] size_in;
    logic          line_valid;
    logic [CW-1:0] line_data;
    logic          line_ready;
    logic          inc;
    logic [DW-1:0] array;
    logic [DW-1:0] size_out;
    logic          word_last;
    logic          done;
    logic          busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [63:0] sum;
    int   run_len;
    int   last_run;
    logic last_prev;
    logic zero_job;
    logic saw_block;

    line_unpack_pl #(
        .CACHE_WIDTH (CW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .size_in    (size_in),
        .line_valid (line_valid),
        .line_data  (line_data),
        .line_ready (line_ready),
        .inc        (inc),
        .array      (array),
        .size_out   (size_out),
        .word_last  (word_last),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic logic [CW-1:0] mk_line(input int base);
        logic [CW-1:0] l;
        l = '0;
        for (int i = 0; i < CW / DW; i++) begin
            l[i*DW +: DW] = DW'(base + i);
        end
        return l;
    endfunction

    // Monitor: compares every emitted word against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            last_prev = 1'b0;
            run_len   = 0;
        end else begin
            if (inc) begin
                run_len++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_inc", 64'(array), 64'hFFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("array", 64'(array), 64'(e.data));
                    chk("word_last", 64'(word_last), 64'(e.last));
                end
                sum = sum + 64'(array);
                if (word_last) begin
                    last_run = run_len;
                    chk("busy_on_last", 64'(busy), 64'd1);
                end
            end else begin
                run_len = 0;
            end
            if (last_prev) begin
                chk("done_after_last", 64'(done), 64'd1);
                chk("busy_after_last", 64'(busy), 64'd0);
            end else if (done && !zero_job) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end
            last_prev = inc && word_last;
        end
    end

    task automatic start_job(input int n);
        sum       = '0;
        last_run  = 0;
        start     = 1'b1;
        size_in   = DW'(n);
        @(posedge clk); #1;
        start     = 1'b0;
        size_in   = '0;
    endtask

    task automatic send_raw(input int base);
        bit ok;
        ok         = 1'b0;
        line_data  = mk_line(base);
        line_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (line_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("line_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        line_valid = 1'b0;
    endtask

    task automatic push_exp(input int base, input int first, input int n);
        for (int i = 0; i < CW / DW; i++) begin
            if (first + i < n) exp_q.push_back('{data: DW'(base + i), last: (first + i == n - 1)});
        end
    endtask

    task automatic send_line(input int base, input int first, input int n);
        push_exp(base, first, n);
        send_raw(base);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        size_in    = '0;
        line_valid = 1'b0;
        line_data  = '0;
        sum        = '0;
        run_len    = 0;
        last_run   = 0;
        last_prev  = 1'b0;
        zero_job   = 1'b0;
        saw_block  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inc", 64'(inc), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(line_ready), 64'd0);
        chk("rst_size_out", 64'(size_out), 64'd0);
        chk("rst_word_last", 64'(word_last), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // N=16, one line 1..16
        start_job(16);
        send_line(1, 0, 16);
        wait_done();
        chk("t1_sum", sum, 64'd136);
        chk("t1_drained", 64'(exp_q.size()), 64'd0);
        chk("t1_size_out", 64'(size_out), 64'd16);

        // N=20, two lines, 12 surplus words dropped
        start_job(20);
        send_line(101, 0, 20);
        send_line(201, 16, 20);
        wait_done();
        @(negedge clk);
        chk("t2_ready_after", 64'(line_ready), 64'd0);
        chk("t2_sum", sum, 64'd2546);
        chk("t2_size_out", 64'(size_out), 64'd20);
        chk("t2_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // N=0: done in the cycle after the next edge, nothing emitted
        zero_job = 1'b1;
        start    = 1'b1;
        size_in  = '0;
        @(posedge clk); #1;
        start    = 1'b0;
        @(negedge clk);
        chk("t3_done_early", 64'(done), 64'd0);
        chk("t3_busy0", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_busy1", 64'(busy), 64'd0);
        chk("t3_inc", 64'(inc), 64'd0);
        @(posedge clk); #1;
        zero_job = 1'b0;
        @(posedge clk); #1;

        // N=48 with line_valid held high: FIFO fills, no bubbles
        start_job(48);
        line_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            bit ok;
            ok        = 1'b0;
            line_data = mk_line(1001 + 1000 * j);
            push_exp(1001 + 1000 * j, 16 * j, 48);
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (!line_ready) saw_block = 1'b1;
                if (line_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("t4_ready_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        line_valid = 1'b0;
        wait_done();
        chk("t4_saw_block", 64'(saw_block), 64'd1);
        chk("t4_run_len", 64'(last_run), 64'd48);
        chk("t4_drained", 64'(exp_q.size()), 64'd0);

        // start pulsed mid-job with size_in=5 is ignored
        start_job(24);
        send_line(301, 0, 24);
        start   = 1'b1;
        size_in = DW'(5);
        @(posedge clk); #1;
        start   = 1'b0;
        size_in = '0;
        chk("t5_size_mid", 64'(size_out), 64'd24);
        send_line(401, 16, 24);
        wait_done();
        chk("t5_size_out", 64'(size_out), 64'd24);
        chk("t5_sum", sum, 64'd8172);
        chk("t5_drained", 64'(exp_q.size()), 64'd0);

        // rst at word 7 of N=32
        for (int i = 1; i <= 7; i++) exp_q.push_back('{data: DW'(i), last: 1'b0});
        start_job(32);
        send_raw(1);
        begin
            bit ok;
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (inc && array == DW'(7)) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("t6_word7_timeout", 64'd0, 64'd1);
        end
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_inc", 64'(inc), 64'd0);
        chk("t6_array", 64'(array), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_ready", 64'(line_ready), 64'd0);
        chk("t6_size_out", 64'(size_out), 64'd0);
        chk("t6_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("t6_no_done", 64'(done), 64'd0);
        end
        @(posedge clk); #1;
        start_job(16);
        send_line(501, 0, 16);
        wait_done();
        chk("t6_sum", sum, 64'd8136);
        chk("t6_post_drained", 64'(exp_q.size()), 64'd0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_unpack_pl.md
# line_unpack_pl

Pipelined cache-line unpacker that sits directly upstream of the number accumulator. It accepts CACHE_WIDTH-bit lines from the read-response path and serialises them into DATA_WIDTH-bit words, one per cycle, on the accumulator's `inc`/`array` inputs. It also drives the accumulator's `size_out` with the job's word count. A job is armed with `start`, ends after exactly `size_in` words, and drops surplus words in the final line.

## Interface
- CACHE_WIDTH, 512, line width in bits; integer multiple of DATA_WIDTH
- DATA_WIDTH, 32, word width in bits; W = CACHE_WIDTH/DATA_WIDTH words per line (16 at defaults)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle job start; sampled only in IDLE
- size_in  in  DATA_WIDTH  job length N in words, sampled with start
- line_valid  in  1  line_data valid
- line_data  in  CACHE_WIDTH  cache line; word i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- line_ready  out  1  unit can take a line this cycle
- inc  out  1  word valid (to accumulator inc)
- array  out  DATA_WIDTH  word data (to accumulator array)
- size_out  out  DATA_WIDTH  latched N (to accumulator size_out)
- word_last  out  1  qualifies inc; final word of job
- done  out  1  one-cycle pulse at job end
- busy  out  1  high in RUN

## Operation
- Reset: every output is 0; FIFO is empty; word index is 0; remaining count is 0; state is IDLE.
- States are IDLE, RUN, DONE.
- IDLE: on start with N>0, latch size_out=N and remaining=N, then go to RUN. On start with N=0, go to DONE without emitting any word.
- RUN: line_ready = (fifo_count < 2). The registered count is used; a pop in the same cycle does not open ready. A line is pushed when line_valid && line_ready.
- Emit: each cycle the FIFO is non-empty, one word is registered to array with inc=1. The word is taken from the head line at index idx. After each emit, idx increments and remaining decrements.
- Pop the head when idx==W-1. On a pop, idx wraps to 0.
- When remaining==1, the emitted word carries word_last=1. The head is discarded regardless of idx, so surplus words are never output. The state goes to DONE.
- DONE: lasts one cycle. done=1, the FIFO is flushed, idx is set to 0, then the state returns to IDLE. size_out holds its value until the next start.
- start outside IDLE is ignored.
- line_valid outside RUN is ignored; line_ready=0 there.
- Arithmetic: remaining and size_out are unsigned DATA_WIDTH. idx is clog2(W) bits.
- rst asserted mid-job: returns the block to reset state on the next edge. The job is aborted and no done pulse is produced.

## Timing
- A line accepted at edge k has word 0 on array (inc=1) in the cycle after edge k+1. Latency is 2 cycles.
- If the next line is already in the FIFO when the head pops, the words are back-to-back with no bubble. Sustained rate is one word per cycle.
- The last word (word_last=1) is in cycle c; done=1 in cycle c+1; busy falls in cycle c+1.
- A start with N=0 at edge k gives done=1 in the cycle after edge k+1. inc stays 0.
- inc, array and word_last are registered. inc=0 in any cycle with no emit. array is don't-care when inc=0.
- The output has no backpressure. The consumer must accept one word every cycle.

## Structure
- Shared package `unpack_pkg`: state enum (IDLE, RUN, DONE), the W calculation, and the idx width function.
- Sub-module `line_fifo2`: a 2-entry CACHE_WIDTH FIFO with push, pop, flush, count, and registered head output.

## Test plan
- N=16, one line with words 1..16: 16 consecutive inc pulses with array=1..16. word_last is set on 16, done follows, and the accumulator res=136.
- N=20, two lines: 20 words are emitted and the last 12 words of line 2 are dropped. done occurs 1 cycle after word 20, and line_ready=0 afterwards.
- N=0 start: done=1 in the cycle after the next edge, no inc, and busy stays 0.
- N=48 with line_valid held high: the FIFO fills and line_ready drops when count==2. The output stream has no bubbles across all 48 words.
- start pulsed again mid-job with size_in=5: ignored, size_out is unchanged, and the job completes with the original N.
- rst at word 7 of N=32: all outputs are 0 the next cycle and there is no done. A new start with N=16 then runs correctly.
